sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param_pkg.sv | 18 +
 rtl/sync_fifo_param_sync_dpram.sv | 29 ++
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the single-clock parametrised FIFO.
package sync_fifo_param_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_sync_dpram.sv
// Simple dual-port RAM, one clock, registered read with read-enable.
module sync_dpram #(
  parameter int WIDTH = 16,
  parameter int PTR   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PTR-1:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [PTR-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << PTR;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable thresholds, occupancy count and sticky error flags.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PTR      = 4,
  parameter int AF_LEVEL = (1 << PTR) - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  output logic             full,
  output logic             almost_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic [PTR:0]     count,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int          DEPTH = 1 << PTR;
  localparam logic [31:0] AF_L  = 32'(AF_LEVEL);
  localparam logic [31:0] AE_L  = 32'(AE_LEVEL);

  logic [PTR:0]     wr_ptr, rd_ptr;
  logic [31:0]      count_w;
  logic             wr_acc, rd_acc;
  logic             ram_we, ram_re;
  logic [WIDTH-1:0] ram_dout;

  assign count_w      = 32'(count);
  assign full         = (count_w == 32'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count_w >= AF_L);
  assign almost_empty = (count_w <= AE_L);
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;
      // a new error event outranks a simultaneous clear
      if (wr_en && full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

  sync_dpram #(
    .WIDTH (WIDTH),
    .PTR   (PTR)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[PTR-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr[PTR-1:0]),
    .rd_data (ram_dout)
  );

  if (FWFT == int'(FIFO_MODE_FWFT)) begin : g_fwft
    // Head word lives either in the bypass register or in the RAM read
    // register; the RAM only holds the words behind the head.
    logic             bypass;
    logic             head_from_ram;
    logic [WIDTH-1:0] byp_data;

    assign bypass   = wr_acc && (empty || (count_w == 32'd1 && rd_acc));
    assign ram_we   = wr_acc && !bypass;
    assign ram_re   = rd_acc && (count_w > 32'd1);
    assign rd_valid = !empty;
    assign rd_data  = head_from_ram ? ram_dout : byp_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        byp_data      <= '0;
        head_from_ram <= 1'b0;
      end else if (bypass) begin
        byp_data      <= wr_data;
        head_from_ram <= 1'b0;
      end else if (ram_re) begin
        head_from_ram <= 1'b1;
      end
    end
  end else begin : g_std
    assign ram_we  = wr_acc;
    assign ram_re  = rd_acc;
    assign rd_data = ram_dout;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_valid <= 1'b0;
      else     rd_valid <= rd_acc;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: one standard and one FWFT FIFO share the same stimulus.
module tb_sync_fifo_param;

  localparam int W = 16;
  localparam int P = 4;
  localparam int D = 16;

  typedef struct {
    logic          wr;
    logic [W-1:0]  d;
    logic          rd;
    logic [P:0]    cnt;
    logic [6:0]    flg;
    logic          chk_d;
    logic [W-1:0]  rdd;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] wr_data = '0;
  logic         wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;

  logic         s_full, s_af, s_rd_valid, s_empty, s_ae, s_overflow, s_underflow;
  logic [W-1:0] s_rd_data;
  logic [P:0]   s_count;
  logic         f_full, f_af, f_rd_valid, f_empty, f_ae, f_overflow, f_underflow;
  logic [W-1:0] f_rd_data;
  logic [P:0]   f_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_q[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0, s_vld = 1'b0;
  logic [W-1:0] s_last = '0;
  vec_t         tbl [34];

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(W), .PTR(P), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(s_full),
    .almost_full(s_af), .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count), .err_clr(err_clr),
    .overflow(s_overflow), .underflow(s_underflow)
  );

  sync_fifo_param #(
    .WIDTH(W), .PTR(P), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(f_full),
    .almost_full(f_af), .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count), .err_clr(err_clr),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  function automatic logic [6:0] exp_flags(input int n, input logic o, input logic u, input logic v);
    return {n == D, n >= 14, n == 0, n <= 2, o, u, v};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_both();
    int n;
    n = m_q.size();
    chk("std_count", 32'(s_count), 32'(n));
    chk("std_flags", 32'({s_full, s_af, s_empty, s_ae, s_overflow, s_underflow, s_rd_valid}),
        32'(exp_flags(n, m_ovf, m_unf, s_vld)));
    chk("std_rd_data", 32'(s_rd_data), 32'(s_last));
    chk("fwft_count", 32'(f_count), 32'(n));
    chk("fwft_flags", 32'({f_full, f_af, f_empty, f_ae, f_overflow, f_underflow, f_rd_valid}),
        32'(exp_flags(n, m_ovf, m_unf, n > 0)));
    if (n > 0) chk("fwft_head", 32'(f_rd_data), 32'(m_q[0]));
  endtask

  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic c);
    logic wacc, racc;
    logic [W-1:0] popped;
    wacc   = w && (m_q.size() < D);
    racc   = r && (m_q.size() > 0);
    popped = s_last;
    if (racc) popped = m_q[0];
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    #1;
    if (racc) void'(m_q.pop_front());
    if (wacc) m_q.push_back(d);
    if (w && !wacc) m_ovf = 1'b1;
    else if (c)     m_ovf = 1'b0;
    if (r && !racc) m_unf = 1'b1;
    else if (c)     m_unf = 1'b0;
    s_vld  = racc;
    s_last = popped;
    check_both();
  endtask

  task automatic check_reset();
    chk("rst_std_count", 32'(s_count), 32'd0);
    chk("rst_std_flags", 32'({s_full, s_af, s_empty, s_ae, s_overflow, s_underflow, s_rd_valid}), 32'h18);
    chk("rst_std_data", 32'(s_rd_data), 32'd0);
    chk("rst_fwft_count", 32'(f_count), 32'd0);
    chk("rst_fwft_flags", 32'({f_full, f_af, f_empty, f_ae, f_overflow, f_underflow, f_rd_valid}), 32'h18);
    chk("rst_fwft_data", 32'(f_rd_data), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      tbl[i] = '{1'b1, 16'(i + 1), 1'b0, 5'(i + 1), exp_flags(i + 1, 1'b0, 1'b0, 1'b0), 1'b0, 16'h0};
    tbl[16] = '{1'b1, 16'h0011, 1'b0, 5'd16, 7'b1100100, 1'b0, 16'h0};
    for (int j = 1; j <= 16; j++)
      tbl[16 + j] = '{1'b0, 16'h0, 1'b1, 5'(16 - j), exp_flags(16 - j, 1'b1, 1'b0, 1'b1), 1'b1, 16'(j)};
    tbl[33] = '{1'b0, 16'h0, 1'b1, 5'd0, 7'b0011110, 1'b0, 16'h0};

    repeat (2) @(posedge clk);
    #1;
    check_reset();
    #2 rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      cyc(tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0);
      chk("tbl_count", 32'(s_count), 32'(tbl[i].cnt));
      chk("tbl_flags", 32'({s_full, s_af, s_empty, s_ae, s_overflow, s_underflow, s_rd_valid}),
          32'(tbl[i].flg));
      if (tbl[i].chk_d) chk("tbl_rd_data", 32'(s_rd_data), 32'(tbl[i].rdd));
    end

    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("unf_kept_with_clr", 32'(s_underflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("err_cleared", 32'({s_overflow, s_underflow}), 32'd0);

    for (int k = 0; k < 16; k++) cyc(1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1);
    chk("ovf_kept_with_clr", 32'(s_overflow), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(s_overflow), 32'd0);

    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 16'h0300 + 16'(k), 1'b1, 1'b0);
      if (k == 0) chk("count_after_full_rw", 32'(s_count), 32'd15);
    end
    repeat (17) cyc(1'b0, '0, 1'b1, 1'b0);

    for (int k = 0; k < 7; k++) cyc(1'b1, 16'h0400 + 16'(k), 1'b0, 1'b0);
    chk("pre_reset_count", 32'(s_count), 32'd7);
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset();
    m_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; s_vld = 1'b0; s_last = '0;
    #2 rst = 1'b0;
    cyc(1'b1, 16'h55AA, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("post_reset_data", 32'(s_rd_data), 32'h55AA);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1);

    cyc(1'b1, 16'hABCD, 1'b0, 1'b0);
    chk("fwft_bypass_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_bypass_data", 32'(f_rd_data), 32'hABCD);
    chk("fwft_bypass_count", 32'(f_count), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("fwft_pop_valid", 32'(f_rd_valid), 32'd0);
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);

    cyc(1'b1, 16'h00A1, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 1'b1, 1'b0);
    cyc(1'b1, 16'h00A3, 1'b1, 1'b0);
    cyc(1'b1, 16'h00A4, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A5, 1'b1, 1'b0);
    chk("fwft_head_from_ram", 32'(f_rd_data), 32'h00A4);
    repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
